fact_bus_receiver: RTL and testbench



---
 rtl/fact_bus_pkg.sv | 17 +
 rtl/fact_bus_receiver_if.sv | 26 ++
 rtl/fact_bus_receiver_sync_fifo.sv | 61 ++++++
 rtl/fact_bus_receiver.sv | 113 +++++++++++
 tb/tb_fact_bus_receiver.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/fact_bus_pkg.sv
// Shared constants for the factorial unit's bus receiver: register map,
// status-word bit positions and control-word bit positions.
package fact_bus_pkg;

    localparam logic [1:0] ADDR_NDATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL  = 2'd1;
    localparam logic [1:0] ADDR_LAST  = 2'd2;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_RERR    = 3;
    localparam int ST_CNT_LSB = 8;

    localparam int CTRL_FLUSH_BIT = 0;

endpackage

// File: rtl/fact_bus_receiver_if.sv
// Shared data bus plus command handshake between the processor side,
// the receiver and the factorial core.
interface fact_bus_if #(
    parameter int DATA_W = 32,
    parameter int N_W    = 4
);
    logic              we;
    logic              re;
    logic [1:0]        addr;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;
    logic              rd_oe;
    logic [N_W-1:0]    cmd_n;
    logic              cmd_valid;
    logic              cmd_ready;

    modport slave (
        input  we, re, addr, wd, cmd_ready,
        output rd, rd_oe, cmd_n, cmd_valid
    );

    modport master (
        output we, re, addr, wd, cmd_ready,
        input  rd, rd_oe, cmd_n, cmd_valid
    );
endinterface

// File: rtl/fact_bus_receiver_sync_fifo.sv
// Small synchronous FIFO; push is accepted while full if a pop happens the
// same cycle, and flush empties it ahead of any push or pop.
module sync_fifo #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             pop_s;
    logic             push_s;

    assign empty  = (count_r == {CW{1'b0}});
    assign full   = (count_r == CW'(DEPTH));
    assign count  = count_r;
    assign pop_s  = pop && !empty;
    assign push_s = push && (!full || pop_s);
    assign dout   = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Storage array; no write lands during reset or flush.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/fact_bus_receiver.sv
// Bus slave for the factorial unit: decodes register writes, queues N values
// for the core, keeps sticky error flags and returns registered readback.
module fact_bus_receiver
    import fact_bus_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_W    = 4,
    parameter int DEPTH  = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    fact_bus_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [N_W-1:0]    fifo_dout_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic [CW-1:0]     fifo_count_s;
    logic              write_ndata_s;
    logic              range_ok_s;
    logic              push_s;
    logic              flush_s;
    logic              pop_fire_s;
    logic [DATA_W-1:0] status_s;
    logic [DATA_W-1:0] read_val_s;
    logic              overflow_r;
    logic              range_err_r;
    logic [N_W-1:0]    last_n_r;
    logic [DATA_W-1:0] rd_r;
    logic              rd_oe_r;

    sync_fifo #(.WIDTH(N_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (bus.cmd_ready),
        .flush (flush_s),
        .din   (bus.wd[N_W-1:0]),
        .dout  (fifo_dout_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s),
        .count (fifo_count_s)
    );

    // Write decode; a flush pre-empts whatever the core is taking this cycle.
    always_comb begin
        write_ndata_s = bus.we && (bus.addr == ADDR_NDATA);
        range_ok_s    = (bus.wd[DATA_W-1:N_W] == {(DATA_W-N_W){1'b0}});
        push_s        = write_ndata_s && range_ok_s;
        flush_s       = bus.we && (bus.addr == ADDR_CTRL) && bus.wd[CTRL_FLUSH_BIT];
        pop_fire_s    = !fifo_empty_s && bus.cmd_ready && !flush_s;
    end

    // Status word and read mux, both from pre-edge state.
    always_comb begin
        status_s                    = {DATA_W{1'b0}};
        status_s[ST_EMPTY]          = fifo_empty_s;
        status_s[ST_FULL]           = fifo_full_s;
        status_s[ST_OVF]            = overflow_r;
        status_s[ST_RERR]           = range_err_r;
        status_s[ST_CNT_LSB +: CW]  = fifo_count_s;
        case (bus.addr)
            ADDR_NDATA: read_val_s = DATA_W'(fifo_count_s);
            ADDR_CTRL:  read_val_s = status_s;
            ADDR_LAST:  read_val_s = DATA_W'(last_n_r);
            default:    read_val_s = {DATA_W{1'b0}};
        endcase
    end

    // Sticky flags and last popped operand.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            range_err_r <= 1'b0;
            last_n_r    <= {N_W{1'b0}};
        end else if (flush_s) begin
            overflow_r  <= 1'b0;
            range_err_r <= 1'b0;
            last_n_r    <= last_n_r;
        end else begin
            if (push_s && fifo_full_s && !pop_fire_s) begin
                overflow_r <= 1'b1;
            end
            if (write_ndata_s && !range_ok_s) begin
                range_err_r <= 1'b1;
            end
            if (pop_fire_s) begin
                last_n_r <= fifo_dout_s;
            end
        end
    end

    // Read pipeline: rd holds between reads so the driver can tri-state it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_r    <= {DATA_W{1'b0}};
            rd_oe_r <= 1'b0;
        end else begin
            rd_oe_r <= bus.re;
            if (bus.re) begin
                rd_r <= read_val_s;
            end else begin
                rd_r <= rd_r;
            end
        end
    end

    assign bus.rd        = rd_r;
    assign bus.rd_oe     = rd_oe_r;
    assign bus.cmd_n     = fifo_dout_s;
    assign bus.cmd_valid = !fifo_empty_s;
endmodule

// File: tb/tb_fact_bus_receiver.sv
// Directed and randomized bench for fact_bus_receiver against a queue-based
// reference model of the register map and command FIFO.
module tb_fact_bus_receiver;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    int          mq[$];
    bit          m_ovf;
    bit          m_rerr;
    int          m_last;
    logic [31:0] m_rd;
    bit          m_oe;

    fact_bus_if #(.DATA_W(32), .N_W(4)) bus ();

    fact_bus_receiver #(.DATA_W(32), .N_W(4), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one edge using the current inputs, then compare.
    task automatic step(input string tag);
        logic [31:0] rv;
        bit fl;
        bit pp;
        if (!rst_n) begin
            mq.delete();
            m_ovf = 1'b0; m_rerr = 1'b0; m_last = 0;
            m_rd = 32'd0; m_oe = 1'b0;
        end else begin
            rv = 32'd0;
            case (bus.addr)
                2'd0: rv = 32'(mq.size());
                2'd1: begin
                    rv[0]    = (mq.size() == 0);
                    rv[1]    = (mq.size() == DEPTH);
                    rv[2]    = m_ovf;
                    rv[3]    = m_rerr;
                    rv[15:8] = 8'(mq.size());
                end
                2'd2: rv = 32'(m_last);
                default: rv = 32'd0;
            endcase
            if (bus.re) begin
                m_rd = rv;
                m_oe = 1'b1;
            end else begin
                m_oe = 1'b0;
            end
            fl = bus.we && (bus.addr == 2'd1) && bus.wd[0];
            pp = (mq.size() > 0) && bus.cmd_ready && !fl;
            if (fl) begin
                mq.delete();
                m_ovf = 1'b0; m_rerr = 1'b0;
            end else begin
                if (pp) m_last = mq.pop_front();
                if (bus.we && bus.addr == 2'd0) begin
                    if (bus.wd > 32'd15) m_rerr = 1'b1;
                    else if (mq.size() == DEPTH) m_ovf = 1'b1;
                    else mq.push_back(int'(bus.wd));
                end
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".rd"}, bus.rd, m_rd);
        chk({tag, ".rd_oe"}, 32'(bus.rd_oe), 32'(m_oe));
        chk({tag, ".cmd_valid"}, 32'(bus.cmd_valid), 32'(mq.size() > 0));
        chk({tag, ".cmd_n"}, 32'(bus.cmd_n), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    endtask

    task automatic cyc(input bit we, input bit re, input logic [1:0] a,
                       input logic [31:0] d, input bit rdy, input string tag);
        bus.we = we; bus.re = re; bus.addr = a; bus.wd = d; bus.cmd_ready = rdy;
        step(tag);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.we = 1'b0; bus.re = 1'b0; bus.addr = 2'd0; bus.wd = 32'd0; bus.cmd_ready = 1'b0;
        step("reset0");
        step("reset1");
        chk("reset.rd_oe", 32'(bus.rd_oe), 32'd0);
        chk("reset.cmd_valid", 32'(bus.cmd_valid), 32'd0);
        rst_n = 1'b1;

        // 1: single push, pop, LAST readback
        chk("t1.pre_valid", 32'(bus.cmd_valid), 32'd0);
        cyc(1'b1, 1'b0, 2'd0, 32'd5, 1'b0, "t1.wr");
        chk("t1.valid_after", 32'(bus.cmd_valid), 32'd1);
        cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, "t1.pop");
        cyc(1'b0, 1'b1, 2'd2, 32'd0, 1'b0, "t1.rdlast");
        chk("t1.last", bus.rd, 32'd5);
        chk("t1.oe", 32'(bus.rd_oe), 32'd1);
        cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, "t1.idle");
        chk("t1.oe_drop", 32'(bus.rd_oe), 32'd0);

        // 2: overflow on fifth write
        cyc(1'b1, 1'b0, 2'd0, 32'd1, 1'b0, "t2.w1");
        cyc(1'b1, 1'b0, 2'd0, 32'd2, 1'b0, "t2.w2");
        cyc(1'b1, 1'b0, 2'd0, 32'd3, 1'b0, "t2.w3");
        cyc(1'b1, 1'b0, 2'd0, 32'd4, 1'b0, "t2.w4");
        cyc(1'b1, 1'b0, 2'd0, 32'd7, 1'b0, "t2.w7");
        cyc(1'b0, 1'b1, 2'd1, 32'd0, 1'b0, "t2.status");
        chk("t2.status_val", bus.rd, 32'h0406);
        for (int i = 1; i <= 4; i++) begin
            chk("t2.order", 32'(bus.cmd_n), 32'(i));
            cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, "t2.pop");
        end

        // 3: push while full with a same-cycle pop, pointer wrap
        cyc(1'b1, 1'b0, 2'd1, 32'd1, 1'b0, "t3.flush");
        for (int i = 11; i <= 14; i++) cyc(1'b1, 1'b0, 2'd0, 32'(i), 1'b0, "t3.fill");
        cyc(1'b1, 1'b0, 2'd0, 32'd9, 1'b1, "t3.pushpop");
        cyc(1'b0, 1'b1, 2'd1, 32'd0, 1'b0, "t3.status");
        chk("t3.status_val", bus.rd, 32'h0402);
        chk("t3.drain0", 32'(bus.cmd_n), 32'd12);
        cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, "t3.pop");
        chk("t3.drain1", 32'(bus.cmd_n), 32'd13);
        cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, "t3.pop");
        chk("t3.drain2", 32'(bus.cmd_n), 32'd14);
        cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, "t3.pop");
        chk("t3.drain3", 32'(bus.cmd_n), 32'd9);
        cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, "t3.pop");

        // 4: range error and clear
        cyc(1'b1, 1'b0, 2'd0, 32'h10, 1'b0, "t4.bad");
        cyc(1'b0, 1'b1, 2'd1, 32'd0, 1'b0, "t4.status");
        chk("t4.status_rerr", bus.rd, 32'h0009);
        cyc(1'b1, 1'b0, 2'd1, 32'd1, 1'b0, "t4.clear");
        cyc(1'b0, 1'b1, 2'd1, 32'd0, 1'b0, "t4.status2");
        chk("t4.status_clr", bus.rd, 32'h0001);

        // 5: flush beats a same-cycle handshake
        cyc(1'b1, 1'b0, 2'd0, 32'd3, 1'b0, "t5.w");
        cyc(1'b1, 1'b0, 2'd0, 32'd6, 1'b0, "t5.w");
        cyc(1'b1, 1'b0, 2'd1, 32'd1, 1'b1, "t5.flush");
        chk("t5.valid", 32'(bus.cmd_valid), 32'd0);
        cyc(1'b0, 1'b1, 2'd2, 32'd0, 1'b0, "t5.last");
        chk("t5.last_val", bus.rd, 32'd9);
        cyc(1'b0, 1'b1, 2'd0, 32'd0, 1'b0, "t5.count");
        chk("t5.count_val", bus.rd, 32'd0);

        // 6: reset during a read
        cyc(1'b1, 1'b0, 2'd0, 32'd3, 1'b0, "t6.w");
        cyc(1'b1, 1'b0, 2'd0, 32'd6, 1'b0, "t6.w");
        rst_n = 1'b0;
        cyc(1'b0, 1'b1, 2'd1, 32'd0, 1'b0, "t6.rst");
        chk("t6.rd", bus.rd, 32'd0);
        chk("t6.oe", 32'(bus.rd_oe), 32'd0);
        chk("t6.valid", 32'(bus.cmd_valid), 32'd0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, 2'd1, 32'd0, 1'b0, "t6.status");
        chk("t6.status_val", bus.rd, 32'h0001);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] d;
            rst_n = ($urandom_range(0, 149) != 0);
            d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 15));
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), d,
                ($urandom_range(0, 2) == 0), "rand");
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
